// File: rtl/ddr3_traffic_checker.sv
// ddr3_traffic_checker
//   Write-then-read-back traffic generator and checker for a DDR3 user port.
//   A run writes NUM_WORDS words (data = index ^ SEED) to consecutive
//   addresses starting at start_address. It then reads them back with at most
//   MAX_OUTSTANDING reads in flight, and compares each returned beat in order.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   start               : begin a run (honoured only in IDLE or DONE)
//   start_address       : first address of the run, latched at start
//   ctrl_ready          : controller accepts the presented request this cycle
//   write_enable        : write request to the controller
//   read_enable         : read request to the controller
//   i_user_data_address : request address
//   i_user_data         : write data
//   o_user_data         : read data from the controller
//   o_user_data_valid   : o_user_data valid (responses arrive in request order)
//   busy, done, pass    : run status; pass is meaningful while done is high
//   error_count         : saturating mismatch count
//   first_error_address : address of the first mismatching word of the run
//   state_o             : current FSM state (debug)
//
// Handshake: a request (write_enable or read_enable, never both) is accepted on
// a rising edge where it and ctrl_ready are both high. Address and data stay
// unchanged until that edge. A request is never withdrawn before acceptance.
module ddr3_traffic_checker #(
  parameter int          ADDRESS_BITWIDTH      = 15,
  parameter int          BANK_ADDRESS_BITWIDTH = 3,
  parameter int          DQ_BITWIDTH           = 16,
  parameter int          NUM_WORDS             = 256,
  parameter int          MAX_OUTSTANDING       = 8,
  parameter logic [15:0] SEED                  = 16'hA5C3
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] start_address,
  input  logic                                             ctrl_ready,
  output logic                                             write_enable,
  output logic                                             read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                           i_user_data,
  input  logic [DQ_BITWIDTH-1:0]                           o_user_data,
  input  logic                                             o_user_data_valid,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             pass,
  output logic [15:0]                                      error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address,
  output logic [2:0]                                       state_o
);

  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int DW = DQ_BITWIDTH;
  localparam logic [DW-1:0] SEED_W    = DW'(SEED);
  localparam logic [15:0]   LAST_IDX  = 16'(NUM_WORDS - 1);
  localparam logic [15:0]   NW16      = 16'(NUM_WORDS);
  localparam logic [3:0]    MAX_OUT   = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic [15:0]     idx_q;       // next request index
  logic [15:0]     chk_q;       // next index to be checked
  logic [3:0]      out_q;       // reads accepted but not yet returned
  logic [AW-1:0]   base_q;
  logic            captured_q;  // first_error_address already holds a value
  logic            we_q, re_q, busy_q, done_q, pass_q;
  logic [AW-1:0]   addr_q, first_q;
  logic [DW-1:0]   data_q;
  logic [15:0]     err_q;

  logic            wr_acc, rd_acc, active, beat, slot_beat, stray_beat, mismatch;
  logic [DW-1:0]   exp_word;
  logic [15:0]     err_d, idx_inc;
  logic [3:0]      out_d;
  logic [AW-1:0]   next_addr;

  assign wr_acc     = we_q & ctrl_ready;
  assign rd_acc     = re_q & ctrl_ready;
  // Beats are only meaningful while a run is active; IDLE/DONE ignore them.
  assign active     = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign beat       = active & o_user_data_valid;
  assign slot_beat  = beat & (out_q != 4'd0);
  // A beat with nothing outstanding cannot be matched to an index.
  assign stray_beat = beat & (out_q == 4'd0);
  assign exp_word   = DW'(chk_q) ^ SEED_W;
  assign mismatch   = slot_beat & (o_user_data != exp_word);
  assign err_d      = ((stray_beat | mismatch) && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  assign out_d      = (rd_acc && !slot_beat) ? out_q + 4'd1 :
                      (!rd_acc && slot_beat) ? out_q - 4'd1 : out_q;
  assign idx_inc    = idx_q + 16'd1;
  assign next_addr  = base_q + AW'(idx_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      chk_q      <= '0;
      out_q      <= '0;
      base_q     <= '0;
      captured_q <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      first_q    <= '0;
      err_q      <= '0;
    end else begin
      // Response checking runs alongside the request side.
      out_q <= out_d;
      err_q <= err_d;
      if (slot_beat) chk_q <= chk_q + 16'd1;
      if (mismatch && !captured_q) begin
        first_q    <= base_q + AW'(chk_q);
        captured_q <= 1'b1;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_WRITE;
            base_q     <= start_address;
            idx_q      <= '0;
            chk_q      <= '0;
            out_q      <= '0;
            err_q      <= '0;
            first_q    <= '0;
            captured_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            // First write is presented on the first WRITE cycle.
            we_q       <= 1'b1;
            addr_q     <= start_address;
            data_q     <= SEED_W;
          end
        end
        S_WRITE: begin
          if (wr_acc) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_READ;
              we_q    <= 1'b0;
              re_q    <= 1'b1;
              idx_q   <= '0;
              addr_q  <= base_q;
            end else begin
              idx_q  <= idx_inc;
              addr_q <= next_addr;
              data_q <= DW'(idx_inc) ^ SEED_W;
            end
          end
        end
        S_READ: begin
          if (rd_acc && (idx_q == LAST_IDX)) begin
            state_q <= S_DRAIN;
            re_q    <= 1'b0;
          end else begin
            // re is registered, so gate it on next cycle's outstanding count.
            // An unaccepted read stays up because outstanding cannot grow.
            re_q <= (out_d < MAX_OUT);
            if (rd_acc) begin
              idx_q  <= idx_inc;
              addr_q <= next_addr;
            end
          end
        end
        S_DRAIN: begin
          if ((out_q == 4'd0) && (chk_q == NW16)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 16'd0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign write_enable        = we_q;
  assign read_enable         = re_q;
  assign i_user_data_address = addr_q;
  assign i_user_data         = data_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign pass                = pass_q;
  assign error_count         = err_q;
  assign first_error_address = first_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Bench for ddr3_traffic_checker: loopback memory with configurable response
// delay and corruption, request scoreboard, and end-of-run status checks.
module tb_ddr3_traffic_checker;

  localparam int AW   = 18;
  localparam int DW   = 16;
  localparam int NW   = 12;
  localparam int MAXO = 8;
  localparam int W    = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_address = '0;
  logic          ctrl_ready = 1'b1;
  logic          write_enable, read_enable;
  logic [AW-1:0] i_user_data_address;
  logic [DW-1:0] i_user_data;
  logic [DW-1:0] o_user_data = '0;
  logic          o_user_data_valid = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   error_count;
  logic [AW-1:0] first_error_address;
  logic [2:0]    state_o;

  ddr3_traffic_checker #(
    .ADDRESS_BITWIDTH(15), .BANK_ADDRESS_BITWIDTH(3), .DQ_BITWIDTH(DW),
    .NUM_WORDS(NW), .MAX_OUTSTANDING(MAXO), .SEED(16'hA5C3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_address(start_address),
    .ctrl_ready(ctrl_ready), .write_enable(write_enable), .read_enable(read_enable),
    .i_user_data_address(i_user_data_address), .i_user_data(i_user_data),
    .o_user_data(o_user_data), .o_user_data_valid(o_user_data_valid),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .first_error_address(first_error_address), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- shared state ----------------
  typedef struct { logic [DW-1:0] data; int due; } resp_t;
  logic [W-1:0]  exp_q[$];
  resp_t         resp_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            checks = 0;
  int            errors = 0;
  int            inflight = 0, max_inflight = 0, beats = 0;
  int            first_wr_cycle = -1, last_wr_cycle = -1;
  int            ready_mode = 0, resp_delay = 0;
  bit            corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  bit            pend_v = 1'b0;
  logic [W-1:0]  pend = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  initial forever begin
    @(negedge clk);
    ctrl_ready = (ready_mode == 1) ? ~ctrl_ready : 1'b1;
  end

  // Loopback responder: returns read data in order once its due cycle arrives.
  initial forever begin
    @(negedge clk);
    if (resp_q.size() > 0 && resp_q[0].due <= cycle) begin
      o_user_data_valid = 1'b1;
      o_user_data       = resp_q[0].data;
      resp_q.delete(0);
      inflight--;
      beats++;
    end else begin
      o_user_data_valid = 1'b0;
      o_user_data       = '0;
    end
  end

  task automatic do_start(input logic [AW-1:0] base);
    @(negedge clk);
    start_address = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    logic [W-1:0]  cur;
    logic [DW-1:0] rd;
    resp_t         r;
    @(negedge clk);
    #2;
    if (!reset) begin
      if (write_enable || read_enable) begin
        check("we_re_exclusive", 64'(write_enable && read_enable), 64'd0);
        cur = {write_enable, i_user_data_address, write_enable ? i_user_data : {DW{1'b0}}};
        if (pend_v) check("req_held", 64'(cur), 64'(pend));
        if (ctrl_ready) begin
          pend_v = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_request", 64'(cur), 64'd0);
          end else begin
            check("request", 64'(cur), 64'(exp_q[0]));
            exp_q.delete(0);
          end
          if (write_enable) begin
            mem[i_user_data_address] = i_user_data;
            if (first_wr_cycle < 0) first_wr_cycle = cycle;
            last_wr_cycle = cycle;
          end else begin
            rd = mem.exists(i_user_data_address) ? mem[i_user_data_address] : '0;
            if (corrupt_en && i_user_data_address == corrupt_addr) rd = rd ^ 16'h0001;
            r.data = rd;
            r.due  = cycle + 1 + resp_delay;
            resp_q.push_back(r);
            inflight++;
            if (inflight > max_inflight) max_inflight = inflight;
            check("inflight_limit", 64'(inflight <= MAXO), 64'd1);
          end
        end else begin
          pend_v = 1'b1;
          pend   = cur;
        end
      end else if (pend_v) begin
        check("req_dropped", 64'd0, 64'd1);
        pend_v = 1'b0;
      end
    end
  end

  // ---------------- test helpers ----------------
  task automatic push_expected(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < NW; i++) begin
      a = base + AW'(i);
      d = DW'(i) ^ 16'hA5C3;
      exp_q.push_back({1'b1, a, d});
    end
    for (int i = 0; i < NW; i++) begin
      a = base + AW'(i);
      exp_q.push_back({1'b0, a, {DW{1'b0}}});
    end
  endtask

  task automatic setup(input int rmode, input int delay, input bit cor, input logic [AW-1:0] caddr);
    ready_mode = rmode; resp_delay = delay; corrupt_en = cor; corrupt_addr = caddr;
    mem.delete();
    max_inflight = 0; beats = 0; first_wr_cycle = -1; last_wr_cycle = -1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      #3;
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_beats_at_done"}, 64'(beats), 64'(NW));
  endtask

  task automatic finish_checks(input string tag, input bit exp_pass, input logic [15:0] exp_err,
                               input logic [AW-1:0] exp_first);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_state"}, 64'(state_o), 64'd4);
    check({tag, "_pass"}, 64'(pass), 64'(exp_pass));
    check({tag, "_error_count"}, 64'(error_count), 64'(exp_err));
    check({tag, "_first_error_address"}, 64'(first_error_address), 64'(exp_first));
    check({tag, "_inflight"}, 64'(inflight), 64'd0);
    check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run(input string tag, input logic [AW-1:0] base, input int rmode, input int delay,
                     input bit cor, input logic [AW-1:0] caddr,
                     input bit exp_pass, input logic [15:0] exp_err, input logic [AW-1:0] exp_first);
    setup(rmode, delay, cor, caddr);
    push_expected(base);
    do_start(base);
    wait_done(tag);
    finish_checks(tag, exp_pass, exp_err, exp_first);
  endtask

  // ---------------- global watchdog ----------------
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_write_enable", 64'(write_enable), 64'd0);
    check("rst_read_enable", 64'(read_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_error_count", 64'(error_count), 64'd0);
    check("rst_first_error_address", 64'(first_error_address), 64'd0);
    check("rst_address", 64'(i_user_data_address), 64'd0);
    check("rst_data", 64'(i_user_data), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Ideal loopback from address 0; a second start during WRITE must be ignored.
    fork
      run("basic", 18'h0, 0, 0, 1'b0, 18'h0, 1'b1, 16'd0, 18'h0);
      begin
        repeat (4) @(negedge clk);
        start_address = 18'h00055;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("basic_write_cycles", 64'(last_wr_cycle - first_wr_cycle), 64'(NW - 1));
    check("basic_mem_word0", 64'(mem[18'h0]), 64'h0000A5C3);
    check("basic_mem_word3", 64'(mem[18'h3]), 64'h0000A5C0);

    // Word 2 corrupted on the way back.
    run("corrupt", 18'h0, 0, 0, 1'b1, 18'h2, 1'b0, 16'd1, 18'h2);

    // ctrl_ready toggling: every request held until accepted.
    run("toggle", 18'h00100, 1, 0, 1'b0, 18'h0, 1'b1, 16'd0, 18'h0);

    // 20-cycle response delay: outstanding reads must saturate at MAXO.
    run("delay", 18'h01000, 0, 20, 1'b0, 18'h0, 1'b1, 16'd0, 18'h0);
    check("delay_max_inflight", 64'(max_inflight), 64'(MAXO));

    // Address wrap-around from all-ones.
    run("wrap", 18'h3FFFF, 0, 0, 1'b0, 18'h0, 1'b1, 16'd0, 18'h0);
    check("wrap_mem_last", 64'(mem[18'h3FFFF]), 64'h0000A5C3);
    check("wrap_mem_zero", 64'(mem[18'h0]), 64'h0000A5C2);

    // Reset in the middle of READ, then a clean run.
    setup(0, 20, 1'b0, 18'h0);
    push_expected(18'h0);
    do_start(18'h0);
    n = 0;
    while (!read_enable && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("midrst_reached_read", 64'(read_enable), 64'd1);
    repeat (3) @(negedge clk);
    #4;
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_read_enable", 64'(read_enable), 64'd0);
    check("midrst_write_enable", 64'(write_enable), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_address", 64'(i_user_data_address), 64'd0);
    check("midrst_state", 64'(state_o), 64'd0);
    exp_q.delete();
    resp_q.delete();
    inflight = 0;
    pend_v = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run("after_reset", 18'h00200, 0, 3, 1'b0, 18'h0, 1'b1, 16'd0, 18'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_traffic_checker.md
DDR3_TRAFFIC_CHECKER -- requirements
Module: ddr3_traffic_checker

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 15: row/column address width of the DDR3 device.
REQ-002 SHALL have parameter BANK_ADDRESS_BITWIDTH, default 3: bank address width (8 banks).
REQ-003 SHALL have parameter DQ_BITWIDTH, default 16: user data word width.
REQ-004 SHALL have parameter NUM_WORDS, default 256: words written and then read back per run (range 1..65535).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8: read requests allowed in flight (range 1..15).
REQ-006 SHALL have parameter SEED, default 16'hA5C3: data pattern seed, truncated to DQ_BITWIDTH.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: run request, sampled on clk.
REQ-010 SHALL have port start_address, input, BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH bits: first address of a run, latched when a run starts.
REQ-011 SHALL have port ctrl_ready, input, 1 bit: controller accepts a request this cycle.
REQ-012 SHALL have port write_enable, output, 1 bit: write request to the controller.
REQ-013 SHALL have port read_enable, output, 1 bit: read request to the controller.
REQ-014 SHALL have port i_user_data_address, output, BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH bits: request address.
REQ-015 SHALL have port i_user_data, output, DQ_BITWIDTH bits: write data.
REQ-016 SHALL have port o_user_data, input, DQ_BITWIDTH bits: read data returned by the controller.
REQ-017 SHALL have port o_user_data_valid, input, 1 bit: o_user_data is valid; responses arrive in request order.
REQ-018 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-019 SHALL have port done, output, 1 bit: a run has completed; stays high until the next run starts.
REQ-020 SHALL have port pass, output, 1 bit: valid while done is high; high when error_count is 0.
REQ-021 SHALL have port error_count, output, 16 bits: mismatch count; saturates at 16'hFFFF.
REQ-022 SHALL have port first_error_address, output, BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH bits: address of the first mismatch in a run.

Function
REQ-023 SHALL implement these states: IDLE, WRITE, READ, DRAIN, DONE.
REQ-024 SHALL apply this pattern: word n (n = 0..NUM_WORDS-1) is stored at address start_address+n, modulo 2^(BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH), with data n[DQ_BITWIDTH-1:0] XOR SEED.
REQ-025 SHALL, in IDLE or DONE, on start=1: latch start_address, clear error_count, first_error_address and done, then enter WRITE on the next cycle.
REQ-026 SHALL ignore start in the WRITE, READ and DRAIN states.
REQ-027 SHALL treat a request as accepted on a cycle where (write_enable or read_enable) and ctrl_ready are both high.
REQ-028 SHALL hold the request's address and data stable until it is accepted.
REQ-029 SHALL never assert write_enable and read_enable together.
REQ-030 SHALL, in WRITE: assert write_enable with word n; advance n on acceptance; after word NUM_WORDS-1 is accepted, reset n to 0 and enter READ.
REQ-031 SHALL, in READ: assert read_enable only while outstanding < MAX_OUTSTANDING; after read NUM_WORDS-1 is accepted, enter DRAIN.
REQ-032 SHALL track outstanding: +1 on read acceptance, -1 on o_user_data_valid, unchanged when both occur in the same cycle.
REQ-033 SHALL compare each o_user_data_valid beat with the expected word for the next unchecked index (a separate check counter).
REQ-034 SHALL, on a mismatch, increment error_count (saturating) and, if it is the first mismatch in the run, capture first_error_address.
REQ-035 SHALL, when o_user_data_valid arrives with outstanding = 0, count it as a mismatch without capturing an address.
REQ-036 SHALL, in DRAIN: deassert requests; when outstanding reaches 0 and the check counter equals NUM_WORDS, enter DONE.
REQ-037 SHALL, in DONE: set busy=0, done=1, pass=(error_count==0).
REQ-038 SHALL drive busy high in the WRITE, READ and DRAIN states.

Reset
REQ-039 SHALL, on reset asserted at any time (including mid-run), immediately enter IDLE.
REQ-040 SHALL, during reset, drive write_enable, read_enable, busy, done, pass to 0, clear all counters, and drive error_count, first_error_address, i_user_data_address, i_user_data to 0.
REQ-041 SHALL, after reset, discard any in-flight responses as unexpected only if a new run has started; in IDLE, valid beats are ignored.

Verification
REQ-042 SHALL cover: NUM_WORDS=4, start_address=0, ideal loopback memory, ctrl_ready=1 -> writes A5C3, A5C2, A5C1, A5C0 on addresses 0..3 in 4 cycles, then reads; done=1, pass=1, error_count=0.
REQ-043 SHALL cover: loopback corrupts word 2 -> error_count=1, first_error_address=2, pass=0.
REQ-044 SHALL cover: ctrl_ready toggling 1-0 each cycle -> each request is held until accepted, no word is skipped or duplicated, pass=1.
REQ-045 SHALL cover: responses delayed by 20 cycles, MAX_OUTSTANDING=8 -> no more than 8 reads in flight, DONE reached only after the last beat.
REQ-046 SHALL cover: start_address=all-ones, NUM_WORDS=2 -> second access at address 0 (wrap-around).
REQ-047 SHALL cover: reset asserted during READ -> outputs cleared immediately, IDLE, and a new start gives a clean pass.
